// File: rtl/flex_pts_frame_sr.sv
// Framed parallel-to-serial shifter: accepts a word plus frame length over a valid/ready
// load port and shifts it out one bit per shift_enable strobe, with back-to-back frames.
module flex_pts_frame_sr #(
    parameter int NUM_BITS  = 8,
    parameter int SHIFT_MSB = 1,
    parameter int IDLE_VAL  = 1,
    localparam int LEN_W    = $clog2(NUM_BITS) + 1
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                shift_enable,
    input  logic                load_valid,
    output logic                load_ready,
    input  logic [NUM_BITS-1:0] parallel_in,
    input  logic [LEN_W-1:0]    frame_len,
    output logic                serial_out,
    output logic                busy,
    output logic                frame_done
);

    localparam logic IDLE_BIT = (IDLE_VAL != 0);
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(NUM_BITS);

    // Load handshake: a word transfers on any cycle where load_valid and load_ready are both
    // high; load_ready is combinational and may rise on the last-shift cycle of a frame.
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t               state;
    state_t               next_state;
    logic [NUM_BITS-1:0]  shreg;
    logic [NUM_BITS-1:0]  load_word;
    logic [NUM_BITS-1:0]  shifted;
    logic [LEN_W-1:0]     remaining;
    logic [LEN_W-1:0]     eff_len;
    logic                 last_shift;
    logic                 load;

    always_comb begin
        eff_len = frame_len;
        if (frame_len == '0 || frame_len > MAX_LEN) begin
            eff_len = MAX_LEN;
        end
    end

    // MSB mode left-aligns the frame so bit eff_len-1 sits at the output end.
    always_comb begin
        load_word = parallel_in;
        shifted   = {IDLE_BIT, shreg[NUM_BITS-1:1]};
        if (SHIFT_MSB != 0) begin
            load_word = parallel_in << (MAX_LEN - eff_len);
            shifted   = {shreg[NUM_BITS-2:0], IDLE_BIT};
        end
    end

    always_comb begin
        next_state = state;
        last_shift = 1'b0;
        load_ready = 1'b0;
        case (state)
            IDLE: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    next_state = SHIFT;
                end
            end
            SHIFT: begin
                last_shift = shift_enable && (remaining == LEN_W'(1));
                load_ready = last_shift;
                if (last_shift && !load_valid) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign load = load_valid && load_ready;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state      <= IDLE;
            shreg      <= {NUM_BITS{IDLE_BIT}};
            remaining  <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= next_state;
            frame_done <= last_shift;
            if (load) begin
                shreg     <= load_word;
                remaining <= eff_len;
            end else if (state == SHIFT && shift_enable) begin
                shreg     <= shifted;
                remaining <= remaining - LEN_W'(1);
            end
        end
    end

    assign busy       = (state == SHIFT);
    assign serial_out = (state == SHIFT)
                        ? ((SHIFT_MSB != 0) ? shreg[NUM_BITS-1] : shreg[0])
                        : IDLE_BIT;

endmodule

// File: tb/tb_flex_pts_frame_sr.sv
// Bench for flex_pts_frame_sr: an MSB-first and an LSB-first instance share the stimulus and
// are checked every cycle against a bit-list model, plus hand-computed literal expectations.
module tb_flex_pts_frame_sr;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       shift_enable = 1'b0;
    logic       load_valid = 1'b0;
    logic [7:0] parallel_in = 8'h00;
    logic [3:0] frame_len = 4'd0;
    logic [1:0] so, bz, lr, fd;   // index 1: MSB-first instance, index 0: LSB-first

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    flex_pts_frame_sr #(.NUM_BITS(8), .SHIFT_MSB(1), .IDLE_VAL(1)) u_msb (
        .clk(clk), .n_rst(n_rst), .shift_enable(shift_enable), .load_valid(load_valid),
        .load_ready(lr[1]), .parallel_in(parallel_in), .frame_len(frame_len),
        .serial_out(so[1]), .busy(bz[1]), .frame_done(fd[1]));

    flex_pts_frame_sr #(.NUM_BITS(8), .SHIFT_MSB(0), .IDLE_VAL(1)) u_lsb (
        .clk(clk), .n_rst(n_rst), .shift_enable(shift_enable), .load_valid(load_valid),
        .load_ready(lr[0]), .parallel_in(parallel_in), .frame_len(frame_len),
        .serial_out(so[0]), .busy(bz[0]), .frame_done(fd[0]));

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: each instance holds the word, its effective length and how many bits have gone.
    logic [7:0] m_word [2];
    int         m_len  [2] = '{0, 0};
    int         m_sent [2] = '{0, 0};
    logic       m_done [2] = '{1'b0, 1'b0};

    function automatic int eff_len(input logic [3:0] f);
        return (f == 4'd0 || f > 4'd8) ? 8 : int'(f);
    endfunction

    function automatic logic frame_bit(input int inst, input int k);
        logic [7:0] w;
        w = m_word[inst];
        return (inst == 1) ? w[m_len[inst] - 1 - k] : w[k];
    endfunction

    function automatic logic exp_ready(input int inst);
        int left;
        left = m_len[inst] - m_sent[inst];
        return (left == 0) || (left == 1 && shift_enable);
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!n_rst) begin
                m_len[i]  = 0;
                m_sent[i] = 0;
                m_done[i] = 1'b0;
            end else begin
                logic rdy, active;
                active    = m_sent[i] < m_len[i];
                rdy       = exp_ready(i);
                m_done[i] = active && (m_len[i] - m_sent[i] == 1) && shift_enable;
                if (active && shift_enable) m_sent[i]++;
                if (load_valid && rdy) begin
                    m_word[i] = parallel_in;
                    m_len[i]  = eff_len(frame_len);
                    m_sent[i] = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                logic active;
                active = m_sent[i] < m_len[i];
                chk($sformatf("model_serial[%0d]", i), 16'(so[i]),
                    16'(active ? frame_bit(i, m_sent[i]) : 1'b1));
                chk($sformatf("model_busy[%0d]", i), 16'(bz[i]), 16'(active));
                chk($sformatf("model_ready[%0d]", i), 16'(lr[i]), 16'(exp_ready(i)));
                chk($sformatf("model_done[%0d]", i), 16'(fd[i]), 16'(m_done[i]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [7:0] w, input logic [3:0] len, input logic se);
        load_valid   = 1'b1;
        parallel_in  = w;
        frame_len    = len;
        shift_enable = se;
        tick();
        load_valid   = 1'b0;
        shift_enable = 1'b0;
    endtask

    initial begin
        logic [7:0]  pat8;
        logic [15:0] pat16;
        logic [3:0]  pat4;
        int          dcount;
        logic        acc;

        // Reset held for two edges
        n_rst = 1'b0;
        tick();
        tick();
        chk_en = 1'b1;
        chk("rst_serial", 16'(so[1]), 16'd1);
        chk("rst_busy", 16'(bz[1]), 16'd0);
        chk("rst_done", 16'(fd[1]), 16'd0);
        chk("rst_ready", 16'(lr[1]), 16'd1);
        n_rst = 1'b1;
        tick();

        // Full MSB frame, strobe every 4th cycle
        pat8 = 8'hA5;
        load_word(8'hA5, 4'd0, 1'b0);
        chk("full_busy", 16'(bz[1]), 16'd1);
        for (int k = 0; k < 8; k++) begin
            for (int c = 0; c < 3; c++) begin
                chk($sformatf("full_bit%0d", k), 16'(so[1]), 16'(pat8[7-k]));
                tick();
            end
            shift_enable = 1'b1;
            tick();
            shift_enable = 1'b0;
        end
        chk("full_done", 16'(fd[1]), 16'd1);
        chk("full_idle_busy", 16'(bz[1]), 16'd0);
        chk("full_idle_serial", 16'(so[1]), 16'd1);
        tick();
        chk("full_done_clear", 16'(fd[1]), 16'd0);

        // LSB-first, 4-bit frame, strobe every 2nd cycle
        pat4 = 4'b0101;   // expected line order 1,0,1,0 read from bit 0 upward
        load_word(8'hA5, 4'd4, 1'b0);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("lsb4_bit%0d", k), 16'(so[0]), 16'(pat4[k]));
            tick();
            shift_enable = 1'b1;
            tick();
            shift_enable = 1'b0;
        end
        chk("lsb4_done", 16'(fd[0]), 16'd1);
        chk("lsb4_serial_idle", 16'(so[0]), 16'd1);
        tick();

        // Oversized length clamps to 8 bits
        load_word(8'h5A, 4'd12, 1'b0);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("len12_busy%0d", k), 16'(bz[0]), 16'd1);
            shift_enable = 1'b1;
            tick();
            shift_enable = 1'b0;
        end
        chk("len12_done", 16'(fd[0]), 16'd1);
        tick();

        // Back-to-back: 3C held while A5 shifts, strobe every cycle
        pat16 = 16'hA53C;
        load_word(8'hA5, 4'd0, 1'b0);
        load_valid   = 1'b1;
        parallel_in  = 8'h3C;
        frame_len    = 4'd8;
        shift_enable = 1'b1;
        dcount = 0;
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("b2b_bit%0d", k), 16'(so[1]), 16'(pat16[15-k]));
            chk($sformatf("b2b_busy%0d", k), 16'(bz[1]), 16'd1);
            if (fd[1]) dcount++;
            acc = lr[1] && load_valid;
            tick();
            if (acc) load_valid = 1'b0;
        end
        shift_enable = 1'b0;
        chk("b2b_mid_done_count", 16'(dcount), 16'd1);
        chk("b2b_final_done", 16'(fd[1]), 16'd1);
        chk("b2b_final_busy", 16'(bz[1]), 16'd0);
        tick();

        // Abort after three shifts
        load_word(8'hA5, 4'd0, 1'b0);
        shift_enable = 1'b1;
        repeat (3) tick();
        shift_enable = 1'b0;
        n_rst = 1'b0;
        tick();
        n_rst = 1'b1;
        chk("abort_serial", 16'(so[1]), 16'd1);
        chk("abort_busy", 16'(bz[1]), 16'd0);
        chk("abort_done", 16'(fd[1]), 16'd0);
        for (int k = 0; k < 3; k++) begin
            shift_enable = 1'b1;
            tick();
            shift_enable = 1'b0;
            tick();
            chk($sformatf("abort_quiet_serial%0d", k), 16'(so[1]), 16'd1);
            chk($sformatf("abort_quiet_busy%0d", k), 16'(bz[1]), 16'd0);
        end

        // Load and strobe together in IDLE: the single bit waits for the next strobe
        load_word(8'h80, 4'd1, 1'b1);
        chk("same_busy", 16'(bz[1]), 16'd1);
        tick();
        tick();
        chk("same_held_busy", 16'(bz[1]), 16'd1);
        chk("same_held_done", 16'(fd[1]), 16'd0);
        shift_enable = 1'b1;
        tick();
        shift_enable = 1'b0;
        chk("same_done", 16'(fd[1]), 16'd1);
        chk("same_idle", 16'(bz[1]), 16'd0);
        tick();
        chk("same_done_clear", 16'(fd[1]), 16'd0);
        chk("same_serial_idle", 16'(so[1]), 16'd1);

        // A single-bit frame carrying a 1, LSB-first instance
        load_word(8'h01, 4'd1, 1'b0);
        chk("one_bit_lsb", 16'(so[0]), 16'd1);
        shift_enable = 1'b1;
        tick();
        shift_enable = 1'b0;
        chk("one_bit_done", 16'(fd[0]), 16'd1);
        tick();

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
